// File: rtl/lc3_pkg.sv
// Shared LC-3 condition-code definitions: NZP encodings, the CC type and
// the helper that turns sign/zero information into a one-hot NZP value.
package lc3_pkg;

    typedef logic [2:0] cc_t;

    localparam cc_t CC_N     = 3'b100;
    localparam cc_t CC_Z     = 3'b010;
    localparam cc_t CC_P     = 3'b001;
    localparam cc_t CC_RESET = CC_Z;

    // Zero takes precedence so the result is always exactly one-hot.
    function automatic cc_t cc_from_flags(input logic sign_bit, input logic zero_bit);
        cc_t cc_v;
        if (zero_bit) begin
            cc_v = CC_Z;
        end else if (sign_bit) begin
            cc_v = CC_N;
        end else begin
            cc_v = CC_P;
        end
        return cc_v;
    endfunction

endpackage

// File: rtl/cc_stack.sv
// Saturating LIFO of saved condition codes used across interrupt entry / RTI.
// Illegal requests (overflow, underflow, push+pop) are dropped and flagged.
module cc_stack
    import lc3_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  cc_t              din,
    output cc_t              dout,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             err_pulse
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    cc_t              mem_r [STACK_DEPTH];
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] top_s;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             err_s;
    cc_t              dout_s;

    // Occupancy decode, request qualification and top-of-stack read.
    always_comb begin
        full_s    = (cnt_r == DEPTH_C);
        empty_s   = (cnt_r == ZERO_C);
        top_s     = cnt_r - ONE_C;
        push_ok_s = push & ~pop & ~full_s;
        pop_ok_s  = pop & ~push & ~empty_s;
        err_s     = (push & pop) | (push & ~pop & full_s) | (pop & ~push & empty_s);
        if (empty_s) begin
            dout_s = CC_RESET;
        end else begin
            dout_s = mem_r[top_s[IDX_W-1:0]];
        end
    end

    // Occupancy counter; only qualified requests move it, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= ZERO_C;
        end else if (push_ok_s) begin
            cnt_r <= cnt_r + ONE_C;
        end else if (pop_ok_s) begin
            cnt_r <= top_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_r[cnt_r[IDX_W-1:0]] <= din;
        end
    end

    assign dout      = dout_s;
    assign cnt       = cnt_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign err_pulse = err_s;

endmodule

// File: rtl/cc_ben_unit.sv
// LC-3 condition-code register and branch-enable logic, with a saved-CC
// stack for interrupt entry / RTI and a sticky stack error flag.
module cc_ben_unit
    import lc3_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_cc,
    input  logic              ld_ben,
    input  logic [2:0]        ir_nzp,
    input  logic              cc_push,
    input  logic              cc_pop,
    output logic              n_out,
    output logic              z_out,
    output logic              p_out,
    output logic              ben,
    output logic [CNT_W-1:0]  stack_cnt,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    cc_t  cc_r;
    cc_t  cc_next_s;
    cc_t  bus_cc_s;
    cc_t  stack_dout_s;
    logic ben_r;
    logic ben_next_s;
    logic err_r;
    logic err_pulse_s;
    logic restore_s;

    cc_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (cc_push),
        .pop       (cc_pop),
        .din       (cc_r),
        .dout      (stack_dout_s),
        .cnt       (stack_cnt),
        .full      (stack_full),
        .empty     (stack_empty),
        .err_pulse (err_pulse_s)
    );

    // Next CC (bus load beats stack restore) and BEN from the pre-edge CC.
    always_comb begin
        bus_cc_s  = cc_from_flags(bus_in[DATA_W-1], (bus_in == {DATA_W{1'b0}}));
        restore_s = cc_pop & ~cc_push & ~stack_empty;
        if (ld_cc) begin
            cc_next_s = bus_cc_s;
        end else if (restore_s) begin
            cc_next_s = stack_dout_s;
        end else begin
            cc_next_s = cc_r;
        end
        if (ld_ben) begin
            ben_next_s = |(ir_nzp & cc_r);
        end else begin
            ben_next_s = ben_r;
        end
    end

    // CC, BEN and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_r  <= CC_RESET;
            ben_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            cc_r  <= cc_next_s;
            ben_r <= ben_next_s;
            err_r <= err_r | err_pulse_s;
        end
    end

    assign n_out     = cc_r[2];
    assign z_out     = cc_r[1];
    assign p_out     = cc_r[0];
    assign ben       = ben_r;
    assign stack_err = err_r;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Directed self-checking bench for cc_ben_unit (DATA_W=16, STACK_DEPTH=4).
module tb_cc_ben_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ld_cc;
    logic        ld_ben;
    logic [2:0]  ir_nzp;
    logic        cc_push;
    logic        cc_pop;
    logic        n_out;
    logic        z_out;
    logic        p_out;
    logic        ben;
    logic [2:0]  stack_cnt;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cc_ben_unit #(
        .DATA_W      (16),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_in      (bus_in),
        .ld_cc       (ld_cc),
        .ld_ben      (ld_ben),
        .ir_nzp      (ir_nzp),
        .cc_push     (cc_push),
        .cc_pop      (cc_pop),
        .n_out       (n_out),
        .z_out       (z_out),
        .p_out       (p_out),
        .ben         (ben),
        .stack_cnt   (stack_cnt),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset   = 1'b0;
        bus_in  = 16'h0000;
        ld_cc   = 1'b0;
        ld_ben  = 1'b0;
        ir_nzp  = 3'b000;
        cc_push = 1'b0;
        cc_pop  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load_cc(input logic [15:0] v);
        bus_in = v;
        ld_cc  = 1'b1;
        step();
        ld_cc  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        total_cnt++;
        if ({n_out, z_out, p_out} !== 3'b010) $display("FAIL reset_cc got=%b exp=010", {n_out, z_out, p_out});
        else pass_cnt++;
        total_cnt++;
        if ({ben, stack_err, stack_empty, stack_full} !== 4'b0010)
            $display("FAIL reset_flags got ben/err/empty/full=%b exp=0010", {ben, stack_err, stack_empty, stack_full});
        else pass_cnt++;
        total_cnt++;
        if (stack_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", stack_cnt);
        else pass_cnt++;
    endtask

    task automatic test_nzp_ben();
        logic [15:0] vals [3];
        logic [2:0]  exps [3];
        logic [2:0]  masks [4];
        logic        bexp [4];
        vals  = '{16'h8000, 16'h0000, 16'h0001};
        exps  = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            load_cc(vals[i]);
            total_cnt++;
            if ({n_out, z_out, p_out} !== exps[i]) $display("FAIL nzp_%0d got=%b exp=%b", i, {n_out, z_out, p_out}, exps[i]);
            else pass_cnt++;
        end
        // CC is now 001.
        masks = '{3'b001, 3'b110, 3'b111, 3'b000};
        bexp  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            ir_nzp = masks[i];
            ld_ben = 1'b1;
            step();
            ld_ben = 1'b0;
            total_cnt++;
            if (ben !== bexp[i]) $display("FAIL ben_mask_%b got=%b exp=%b", masks[i], ben, bexp[i]);
            else pass_cnt++;
        end
        // Without ld_ben, ben holds even when the mask would now match.
        ir_nzp = 3'b111;
        step();
        total_cnt++;
        if (ben !== 1'b0) $display("FAIL ben_hold got=%b exp=0", ben);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        load_cc(16'h0000);
        bus_in = 16'hFFFF;
        ld_cc  = 1'b1;
        ir_nzp = 3'b010;
        ld_ben = 1'b1;
        step();
        ld_cc  = 1'b0;
        ld_ben = 1'b0;
        total_cnt++;
        if (ben !== 1'b1) $display("FAIL same_cycle_ben got=%b exp=1", ben);
        else pass_cnt++;
        total_cnt++;
        if ({n_out, z_out, p_out} !== 3'b100) $display("FAIL same_cycle_cc got=%b exp=100", {n_out, z_out, p_out});
        else pass_cnt++;
    endtask

    task automatic test_push_pop();
        do_reset();
        load_cc(16'h0001);
        cc_push = 1'b1; step(); cc_push = 1'b0;
        load_cc(16'h8000);
        cc_push = 1'b1; step(); cc_push = 1'b0;
        total_cnt++;
        if (stack_cnt !== 3'd2) $display("FAIL pp_cnt2 got=%0d exp=2", stack_cnt);
        else pass_cnt++;
        load_cc(16'h0000);
        cc_pop = 1'b1; step();
        total_cnt++;
        if ({n_out, z_out, p_out, stack_cnt} !== {3'b100, 3'd1})
            $display("FAIL pp_pop1 got cc=%b cnt=%0d exp cc=100 cnt=1", {n_out, z_out, p_out}, stack_cnt);
        else pass_cnt++;
        step(); cc_pop = 1'b0;
        total_cnt++;
        if ({n_out, z_out, p_out, stack_cnt, stack_err} !== {3'b001, 3'd0, 1'b0})
            $display("FAIL pp_pop2 got cc=%b cnt=%0d err=%b exp cc=001 cnt=0 err=0", {n_out, z_out, p_out}, stack_cnt, stack_err);
        else pass_cnt++;
        // Push alongside ld_cc saves the pre-update CC (001).
        bus_in = 16'h8000; ld_cc = 1'b1; cc_push = 1'b1;
        step();
        ld_cc = 1'b0; cc_push = 1'b0;
        total_cnt++;
        if ({n_out, z_out, p_out, stack_cnt} !== {3'b100, 3'd1})
            $display("FAIL push_ldcc got cc=%b cnt=%0d exp cc=100 cnt=1", {n_out, z_out, p_out}, stack_cnt);
        else pass_cnt++;
        cc_pop = 1'b1; step(); cc_pop = 1'b0;
        total_cnt++;
        if ({n_out, z_out, p_out} !== 3'b001) $display("FAIL push_ldcc_restore got=%b exp=001", {n_out, z_out, p_out});
        else pass_cnt++;
        // Pop alongside ld_cc: bus wins, entry still consumed.
        cc_push = 1'b1; step(); cc_push = 1'b0;
        bus_in = 16'h0000; ld_cc = 1'b1; cc_pop = 1'b1;
        step();
        ld_cc = 1'b0; cc_pop = 1'b0;
        total_cnt++;
        if ({n_out, z_out, p_out, stack_cnt, stack_err} !== {3'b010, 3'd0, 1'b0})
            $display("FAIL pop_ldcc got cc=%b cnt=%0d err=%b exp cc=010 cnt=0 err=0", {n_out, z_out, p_out}, stack_cnt, stack_err);
        else pass_cnt++;
    endtask

    task automatic test_overflow_underflow();
        logic [15:0] vals [4];
        logic [2:0]  ccs [4];
        vals = '{16'h8000, 16'h0000, 16'h0001, 16'h8000};
        ccs  = '{3'b100, 3'b010, 3'b001, 3'b100};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_cc(vals[i]);
            cc_push = 1'b1; step(); cc_push = 1'b0;
        end
        total_cnt++;
        if ({stack_cnt, stack_full, stack_err} !== {3'd4, 1'b1, 1'b0})
            $display("FAIL fill got cnt=%0d full=%b err=%b exp cnt=4 full=1 err=0", stack_cnt, stack_full, stack_err);
        else pass_cnt++;
        load_cc(16'h0000);
        cc_push = 1'b1; step(); cc_push = 1'b0;
        total_cnt++;
        if ({stack_cnt, stack_full, stack_err} !== {3'd4, 1'b1, 1'b1})
            $display("FAIL overflow got cnt=%0d full=%b err=%b exp cnt=4 full=1 err=1", stack_cnt, stack_full, stack_err);
        else pass_cnt++;
        for (int i = 3; i >= 0; i--) begin
            cc_pop = 1'b1; step(); cc_pop = 1'b0;
            total_cnt++;
            if ({n_out, z_out, p_out, stack_cnt} !== {ccs[i], 3'(i)})
                $display("FAIL lifo_%0d got cc=%b cnt=%0d exp cc=%b cnt=%0d", i, {n_out, z_out, p_out}, stack_cnt, ccs[i], i);
            else pass_cnt++;
        end
        cc_pop = 1'b1; step(); cc_pop = 1'b0;
        total_cnt++;
        if ({n_out, z_out, p_out, stack_cnt, stack_empty} !== {3'b100, 3'd0, 1'b1})
            $display("FAIL extra_pop got cc=%b cnt=%0d empty=%b exp cc=100 cnt=0 empty=1", {n_out, z_out, p_out}, stack_cnt, stack_empty);
        else pass_cnt++;
        // Underflow alone must set the sticky error.
        do_reset();
        cc_pop = 1'b1; step(); cc_pop = 1'b0;
        step();
        total_cnt++;
        if ({stack_err, stack_cnt, n_out, z_out, p_out} !== {1'b1, 3'd0, 3'b010})
            $display("FAIL underflow got err=%b cnt=%0d cc=%b exp err=1 cnt=0 cc=010", stack_err, stack_cnt, {n_out, z_out, p_out});
        else pass_cnt++;
    endtask

    task automatic test_conflict_and_reset();
        do_reset();
        load_cc(16'h0001);
        cc_push = 1'b1; step(); cc_push = 1'b0;
        load_cc(16'h8000);
        cc_push = 1'b1; cc_pop = 1'b1; step(); cc_push = 1'b0; cc_pop = 1'b0;
        total_cnt++;
        if ({stack_cnt, n_out, z_out, p_out, stack_err} !== {3'd1, 3'b100, 1'b1})
            $display("FAIL conflict got cnt=%0d cc=%b err=%b exp cnt=1 cc=100 err=1", stack_cnt, {n_out, z_out, p_out}, stack_err);
        else pass_cnt++;
        // Stored entry survives the conflict.
        cc_pop = 1'b1; step(); cc_pop = 1'b0;
        total_cnt++;
        if ({n_out, z_out, p_out, stack_cnt} !== {3'b001, 3'd0})
            $display("FAIL conflict_entry got cc=%b cnt=%0d exp cc=001 cnt=0", {n_out, z_out, p_out}, stack_cnt);
        else pass_cnt++;
        cc_push = 1'b1; step(); cc_push = 1'b0;
        ir_nzp = 3'b111; ld_ben = 1'b1; step(); ld_ben = 1'b0;
        reset = 1'b1; ld_cc = 1'b1; bus_in = 16'h8000; cc_push = 1'b1; ld_ben = 1'b1;
        step();
        idle_inputs();
        total_cnt++;
        if ({n_out, z_out, p_out, ben, stack_cnt, stack_empty, stack_err} !== {3'b010, 1'b0, 3'd0, 1'b1, 1'b0})
            $display("FAIL mid_reset got cc=%b ben=%b cnt=%0d empty=%b err=%b exp cc=010 ben=0 cnt=0 empty=1 err=0",
                     {n_out, z_out, p_out}, ben, stack_cnt, stack_empty, stack_err);
        else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_nzp_ben();
        test_same_cycle();
        test_push_pop();
        test_overflow_underflow();
        test_conflict_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
